// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the serial pattern generator.
//   state_e      - FSM state encoding (IDLE/SEND/GAP/DONE)
//   DEF_PATTERN  - default bit pattern transmitted MSB first
//   DEF_PAT_LEN  - width of the default pattern
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_PAT_LEN = 4;

endpackage

// File: rtl/seq_gen_cnt.sv
// seq_gen_cnt: loadable down-counter with a zero flag.
//   clk, rst   - clock, asynchronous active-low reset (clears to 0)
//   load       - load load_val (takes priority over dec)
//   load_val   - value to load
//   dec        - decrement by one; holds at zero
//   zero       - high while the count is zero
module seq_gen_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/seq_gen.sv
// seq_gen: transmits PATTERN (MSB first) count times, with gap idle
// bit-times between repetitions, then pulses done.
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   start      - begin a burst (sampled in IDLE only)
//   count      - repetitions, latched on accepted start (0 = ignored)
//   gap        - idle bit-times between repetitions, latched on start
//   abort      - synchronous cancel of a running burst
//   dout       - registered serial data
//   dout_valid - registered, high while dout carries a pattern bit
//   busy       - registered, high outside IDLE
//   done       - registered one-cycle pulse on normal completion
//   dbg_state  - current FSM state
//
// Handshake: start is a level request with no ready; it is accepted on a
// rising edge where the FSM is IDLE, start=1, abort=0 and count!=0. There
// is no back-pressure on dout; each dout_valid=1 cycle is one bit.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter int                 CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam int                IDX_W   = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_LEN - 1);

  state_e             state, next_state;
  logic [IDX_W-1:0]   idx, next_idx;
  logic [1:0]         gap_lat;
  logic               gap_lat_en;
  logic               reps_load, reps_dec, reps_zero;
  logic               gap_load, gap_dec, gap_zero;
  logic [CNT_W-1:0]   reps_load_val;
  logic [1:0]         gap_load_val;

  // Counters hold "remaining minus one" so the zero flag marks the last
  // repetition / last gap cycle and the decision can be made in that cycle.
  assign reps_load_val = count - CNT_W'(1);
  assign gap_load_val  = gap_lat - 2'd1;

  seq_gen_cnt #(.W(CNT_W)) u_reps (
    .clk      (clk),
    .rst      (rst),
    .load     (reps_load),
    .load_val (reps_load_val),
    .dec      (reps_dec),
    .zero     (reps_zero)
  );

  seq_gen_cnt #(.W(2)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_comb begin
    next_state = state;
    next_idx   = idx;
    gap_lat_en = 1'b0;
    reps_load  = 1'b0;
    reps_dec   = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort && (count != '0)) begin
          next_state = SEND;
          next_idx   = IDX_TOP;
          reps_load  = 1'b1;
          gap_lat_en = 1'b1;
        end
      end
      SEND: begin
        if (idx != '0) begin
          next_idx = idx - IDX_W'(1);
        end else if (reps_zero) begin
          next_state = DONE;
        end else begin
          reps_dec = 1'b1;
          if (gap_lat != 2'd0) begin
            next_state = GAP;
            gap_load   = 1'b1;
          end else begin
            next_idx = IDX_TOP;
          end
        end
      end
      GAP: begin
        if (gap_zero) begin
          next_state = SEND;
          next_idx   = IDX_TOP;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Abort overrides everything outside IDLE.
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
      reps_dec   = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe, giving the one-cycle start-to-first-bit latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      gap_lat    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      idx        <= next_idx;
      if (gap_lat_en) begin
        gap_lat <= gap;
      end
      dout       <= (next_state == SEND) && PATTERN[next_idx];
      dout_valid <= (next_state == SEND);
      busy       <= (next_state != IDLE);
      done       <= (next_state == DONE);
    end
  end

  assign dbg_state = state;

endmodule
